// File: rtl/tlb_pkg.sv
// Shared widths, FSM encodings, requester ids and walker result type
// for the TLB refill arbiter.
package tlb_pkg;
  localparam int VPN_W = 20;
  localparam int IDX_W = 4;
  localparam int TMR_W = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WALK = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  typedef struct packed {
    logic             fault;
    logic [VPN_W-1:0] ppn;
  } walk_rsp_t;
endpackage

// File: rtl/tlb_refill_arb_rr_arb2.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to the favoured one.
// Latency: grant is combinational; favour flips on the clock after adv.
// Backpressure: none; the caller decides when a grant is consumed.
module rr_arb2
  import tlb_pkg::*;
#(
  parameter logic FIRST = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic req_itlb,
  input  logic req_dtlb,
  input  logic adv,
  output logic gnt_vld,
  output logic gnt_id
);

  logic favour;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      favour <= FIRST;
    end else if (adv) begin
      favour <= ~favour;
    end
  end

  always_comb begin
    gnt_vld = req_itlb | req_dtlb;
    gnt_id  = favour;
    if (req_itlb && !req_dtlb) begin
      gnt_id = REQ_I;
    end else if (req_dtlb && !req_itlb) begin
      gnt_id = REQ_D;
    end
  end

endmodule

// File: rtl/tlb_refill_arb.sv
// Arbitrates ITLB/DTLB misses onto one page-table walker and writes the result back.
// Latency: req -> w_req 1 cycle; w_done (or timeout) -> ack/we 1 cycle.
// Backpressure: one walk in flight; requesters hold req until their one-cycle ack.
module tlb_refill_arb
  import tlb_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int FIRST   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req,
  input  logic [VPN_W-1:0] i_vpn,
  output logic             i_ack,
  output logic [VPN_W-1:0] i_ppn,
  output logic             i_fault,
  input  logic             d_req,
  input  logic [VPN_W-1:0] d_vpn,
  output logic             d_ack,
  output logic [VPN_W-1:0] d_ppn,
  output logic             d_fault,
  output logic             w_req,
  output logic [VPN_W-1:0] w_vpn,
  input  logic             w_done,
  input  logic [VPN_W-1:0] w_ppn,
  input  logic             w_fault,
  output logic             i_we,
  output logic             d_we,
  output logic [IDX_W-1:0] t_widx,
  output logic [VPN_W-1:0] t_wvpn,
  output logic [VPN_W-1:0] t_wppn
);

  localparam logic [TMR_W-1:0] TMO = TMR_W'(TIMEOUT);

  logic [1:0]       state;
  logic             owner;
  logic [TMR_W-1:0] timer;
  logic [IDX_W-1:0] cnt_i;
  logic [IDX_W-1:0] cnt_d;
  logic             gnt_vld;
  logic             gnt_id;
  walk_rsp_t        rsp;

  rr_arb2 #(.FIRST(FIRST != 0)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_itlb (i_req),
    .req_dtlb (d_req),
    .adv      (state == ST_RESP),
    .gnt_vld  (gnt_vld),
    .gnt_id   (gnt_id)
  );

  // A timeout without w_done becomes a forced fault with ppn 0.
  always_comb begin
    rsp.fault = 1'b1;
    rsp.ppn   = '0;
    if (w_done) begin
      rsp.fault = w_fault;
      rsp.ppn   = w_ppn;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      owner   <= REQ_I;
      timer   <= '0;
      cnt_i   <= '0;
      cnt_d   <= '0;
      w_req   <= 1'b0;
      w_vpn   <= '0;
      i_ack   <= 1'b0;
      i_ppn   <= '0;
      i_fault <= 1'b0;
      d_ack   <= 1'b0;
      d_ppn   <= '0;
      d_fault <= 1'b0;
      i_we    <= 1'b0;
      d_we    <= 1'b0;
      t_widx  <= '0;
      t_wvpn  <= '0;
      t_wppn  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_vld) begin
            owner <= gnt_id;
            w_vpn <= (gnt_id == REQ_D) ? d_vpn : i_vpn;
            w_req <= 1'b1;
            timer <= '0;
            state <= ST_WALK;
          end
        end
        ST_WALK: begin
          if (w_done || timer == TMO) begin
            w_req <= 1'b0;
            w_vpn <= '0;
            state <= ST_RESP;
            if (owner == REQ_I) begin
              i_ack   <= 1'b1;
              i_ppn   <= rsp.ppn;
              i_fault <= rsp.fault;
            end else begin
              d_ack   <= 1'b1;
              d_ppn   <= rsp.ppn;
              d_fault <= rsp.fault;
            end
            if (!rsp.fault) begin
              t_wvpn <= w_vpn;
              t_wppn <= rsp.ppn;
              if (owner == REQ_I) begin
                i_we   <= 1'b1;
                t_widx <= cnt_i;
                cnt_i  <= cnt_i + 1'b1;
              end else begin
                d_we   <= 1'b1;
                t_widx <= cnt_d;
                cnt_d  <= cnt_d + 1'b1;
              end
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_RESP: begin
          i_ack   <= 1'b0;
          i_ppn   <= '0;
          i_fault <= 1'b0;
          d_ack   <= 1'b0;
          d_ppn   <= '0;
          d_fault <= 1'b0;
          i_we    <= 1'b0;
          d_we    <= 1'b0;
          t_widx  <= '0;
          t_wvpn  <= '0;
          t_wppn  <= '0;
          timer   <= '0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_refill_arb.sv
// Scoreboard bench for tlb_refill_arb: directed refills push expected responses,
// a negedge monitor pops and compares whenever an ack or write strobe appears.
module tb_tlb_refill_arb;
  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0;
  logic [19:0] i_vpn = '0, d_vpn = '0;
  logic        i_ack, d_ack, i_fault, d_fault;
  logic [19:0] i_ppn, d_ppn;
  logic        w_req;
  logic [19:0] w_vpn;
  logic        w_done = 1'b0, w_fault = 1'b0;
  logic [19:0] w_ppn = '0;
  logic        i_we, d_we;
  logic [3:0]  t_widx;
  logic [19:0] t_wvpn, t_wppn;

  tlb_refill_arb #(.TIMEOUT(TMO), .FIRST(0)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_vpn(i_vpn), .i_ack(i_ack), .i_ppn(i_ppn), .i_fault(i_fault),
    .d_req(d_req), .d_vpn(d_vpn), .d_ack(d_ack), .d_ppn(d_ppn), .d_fault(d_fault),
    .w_req(w_req), .w_vpn(w_vpn), .w_done(w_done), .w_ppn(w_ppn), .w_fault(w_fault),
    .i_we(i_we), .d_we(d_we), .t_widx(t_widx), .t_wvpn(t_wvpn), .t_wppn(t_wppn)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          who;
    logic [19:0] ppn;
    bit          flt;
    bit          we;
    logic [3:0]  idx;
    logic [19:0] vpn;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int mdl_ci = 0;
  int mdl_cd = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_ctl"}, 64'({i_ack, i_fault, d_ack, d_fault, w_req, i_we, d_we, t_widx}), 64'(0));
    chk({name, "_dat"}, 64'(i_ppn | d_ppn | w_vpn | t_wvpn | t_wppn), 64'(0));
  endtask

  // Monitor: every ack/we appearance must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst && (i_ack || d_ack || i_we || d_we)) begin
      if (q.size() == 0) begin
        chk("unexpected_ack", 64'({i_ack, d_ack, i_we, d_we}), 64'(0));
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("ack_i", 64'(i_ack), 64'(e.who == 1'b0));
        chk("ack_d", 64'(d_ack), 64'(e.who == 1'b1));
        chk("ack_ppn", 64'(e.who ? d_ppn : i_ppn), 64'(e.ppn));
        chk("ack_fault", 64'(e.who ? d_fault : i_fault), 64'(e.flt));
        chk("we_i", 64'(i_we), 64'(!e.who && e.we));
        chk("we_d", 64'(d_we), 64'(e.who && e.we));
        chk("w_req_in_resp", 64'(w_req), 64'(0));
        chk("ack_cycle", 64'(cyc), 64'(e.cyc));
        if (e.we) begin
          chk("t_widx", 64'(t_widx), 64'(e.idx));
          chk("t_wvpn", 64'(t_wvpn), 64'(e.vpn));
          chk("t_wppn", 64'(t_wppn), 64'(e.ppn));
        end
      end
    end
  end

  task automatic set_req(input bit who, input bit val, input logic [19:0] vpn);
    if (who) begin d_req = val; d_vpn = vpn; end
    else     begin i_req = val; i_vpn = vpn; end
  endtask

  task automatic wait_wreq(output int c1, output bit ok);
    ok = 1'b0;
    c1 = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (w_req) begin ok = 1'b1; c1 = cyc; end
    end
    if (!ok) chk("w_req_seen", 64'(0), 64'(1));
  endtask

  task automatic wait_ack(input bit who);
    bit got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (who ? d_ack : i_ack) got = 1'b1;
    end
    if (!got) chk("ack_seen", 64'(0), 64'(1));
    @(posedge clk); #1;
    set_req(who, 1'b0, '0);
  endtask

  // Serve the walk in progress; lat < 0 keeps the walker silent to force a timeout.
  task automatic serve(input bit who, input logic [19:0] vpn, input int lat,
                       input logic [19:0] ppn, input bit flt, output int c1);
    exp_t e;
    bit ok;
    wait_wreq(c1, ok);
    if (ok) begin
      chk("w_vpn", 64'(w_vpn), 64'(vpn));
      e.who = who;
      e.vpn = vpn;
      if (lat < 0) begin
        e.ppn = '0; e.flt = 1'b1; e.we = 1'b0; e.idx = '0;
        e.cyc = c1 + TMO + 1;
        q.push_back(e);
      end else begin
        repeat (lat) @(posedge clk);
        #1;
        w_done = 1'b1; w_ppn = ppn; w_fault = flt;
        e.ppn = ppn; e.flt = flt; e.we = !flt;
        e.idx = who ? 4'(mdl_cd) : 4'(mdl_ci);
        e.cyc = cyc + 1;
        if (e.we) begin
          if (who) mdl_cd = (mdl_cd + 1) % 16;
          else     mdl_ci = (mdl_ci + 1) % 16;
        end
        q.push_back(e);
        @(posedge clk); #1;
        w_done = 1'b0; w_ppn = '0; w_fault = 1'b0;
      end
    end
    wait_ack(who);
  endtask

  task automatic refill(input bit who, input logic [19:0] vpn, input int lat,
                        input logic [19:0] ppn, input bit flt);
    int c1;
    set_req(who, 1'b1, vpn);
    serve(who, vpn, lat, ppn, flt, c1);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    i_req = 1'b0; d_req = 1'b0;
    #1;
    chk_quiet("reset");
    mdl_ci = 0; mdl_cd = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int c0, c1;
    bit ok;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_quiet("por");
    @(posedge clk); #1;
    rst = 1'b1;

    // Basic ITLB refill with exact cycle timing.
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 20'h12345);
    c0 = cyc;
    serve(1'b0, 20'h12345, 3, 20'hABCDE, 1'b0, c1);
    chk("wreq_latency", 64'(c1), 64'(c0 + 1));

    // Simultaneous requests after reset: ITLB, DTLB, then ITLB first again.
    apply_reset();
    set_req(1'b0, 1'b1, 20'h11111);
    set_req(1'b1, 1'b1, 20'h22222);
    serve(1'b0, 20'h11111, 2, 20'h0A0A0, 1'b0, c1);
    serve(1'b1, 20'h22222, 2, 20'h0B0B0, 1'b0, c1);
    set_req(1'b0, 1'b1, 20'h33333);
    set_req(1'b1, 1'b1, 20'h44444);
    serve(1'b0, 20'h33333, 1, 20'h0C0C0, 1'b0, c1);
    serve(1'b1, 20'h44444, 4, 20'h0D0D0, 1'b0, c1);

    // Silent walker forces a DTLB fault; counters untouched by it.
    apply_reset();
    refill(1'b1, 20'hDEAD0, -1, '0, 1'b0);
    refill(1'b1, 20'hDEAD1, 2, 20'h00777, 1'b0);
    // Walker fault reported without a TLB write.
    refill(1'b0, 20'h0F00F, 2, 20'h12121, 1'b1);
    // w_done in the very cycle the timer reaches TIMEOUT wins over the timeout.
    refill(1'b0, 20'h54321, TMO, 20'h00001, 1'b0);

    // Replacement counter wrap: 17 ITLB refills give indices 0..15 then 0.
    apply_reset();
    for (int k = 0; k < 17; k++) begin
      refill(1'b0, 20'(20'h30000 + k), 1 + (k % 3), 20'(20'h50000 + k), 1'b0);
    end
    refill(1'b1, 20'h77777, 2, 20'h88888, 1'b0);

    // Reset mid-walk: late walker result is ignored, counters restart at 0.
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 20'h99999);
    wait_wreq(c1, ok);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk_quiet("midwalk_reset");
    i_req = 1'b0;
    mdl_ci = 0; mdl_cd = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    w_done = 1'b1; w_ppn = 20'h55555;
    @(posedge clk); #1;
    w_done = 1'b0; w_ppn = '0;
    repeat (3) @(negedge clk);
    chk_quiet("after_late_done");
    refill(1'b0, 20'h9999A, 2, 20'h66666, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
